// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Wide enough to hold the digit count itself, not just NDIG-1.
    function automatic int cnt_width(input int ndig);
        return $clog2(ndig + 1);
    endfunction

endpackage

// File: rtl/full_sub_cell.sv
// One-bit full subtractor built from two half-subtractor stages and an OR.
module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;

    assign d1   = a ^ b;
    assign b1   = ~a & b;
    assign d    = d1 ^ bin;
    assign b2   = ~d1 & bin;
    assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b mod 2^WIDTH, DIGIT bits per clock, LSB first.
// Optional signed overflow output enabled by defining SERIAL_SUB_SIGNED_OVF_EN.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// BUSY  | processing one digit per clock
// DONE  | result presented, waiting for out_ready
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             busy
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = cnt_width(NDIG);

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_subtractor: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   res_sh;
    logic [WIDTH-1:0]   res_next;
    logic               bor_q;
    logic [CNT_W-1:0]   cnt;
    logic               last_digit;
    logic [DIGIT-1:0]   d_digit;
    logic [DIGIT:0]     bchain;

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic               sign_a;
    logic               sign_b;
`endif

    assign bchain[0] = bor_q;

    generate
        for (genvar i = 0; i < DIGIT; i++) begin : g_cell
            full_sub_cell u_cell (
                .a    (a_sh[i]),
                .b    (b_sh[i]),
                .bin  (bchain[i]),
                .d    (d_digit[i]),
                .bout (bchain[i+1])
            );
        end
    endgenerate

    // New digit enters at the MSB end so the result lands LSB-aligned after NDIG shifts.
    assign res_next   = (res_sh >> DIGIT) | (WIDTH'(d_digit) << (WIDTH - DIGIT));
    assign last_digit = (cnt == CNT_W'(NDIG - 1));

    assign in_ready  = (state == IDLE);
    assign busy      = (state == BUSY);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = BUSY;
            BUSY:    if (last_digit) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            bor_q  <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        bor_q <= 1'b0;
                        cnt   <= '0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                        sign_a <= a[WIDTH-1];
                        sign_b <= b[WIDTH-1];
`endif
                    end
                end
                BUSY: begin
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    res_sh <= res_next;
                    bor_q  <= bchain[DIGIT];
                    cnt    <= cnt + CNT_W'(1);
                    if (last_digit) begin
                        diff   <= res_next;
                        borrow <= bchain[DIGIT];
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                        ovf    <= (sign_a ^ sign_b) & (res_next[WIDTH-1] ^ sign_a);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: three parameterisations against an arithmetic model.
module tb_serial_subtractor;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    // WIDTH=8, DIGIT=1
    logic       iv8, rdy8, ov8, or8, bo8, bz8;
    logic [7:0] a8, b8, d8;
    // WIDTH=4, DIGIT=1
    logic       iv4, rdy4, ov4, or4, bo4, bz4;
    logic [3:0] a4, b4, d4;
    // WIDTH=8, DIGIT=4
    logic       iv84, rdy84, ov84, or84, bo84, bz84;
    logic [7:0] a84, b84, d84;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic       ovf8, ovf4, ovf84;
`endif

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy8), .a(a8), .b(b8),
        .out_valid(ov8), .out_ready(or8), .diff(d8), .borrow(bo8), .busy(bz8)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        , .ovf(ovf8)
`endif
    );

    serial_subtractor #(.WIDTH(4), .DIGIT(1)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(rdy4), .a(a4), .b(b4),
        .out_valid(ov4), .out_ready(or4), .diff(d4), .borrow(bo4), .busy(bz4)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        , .ovf(ovf4)
`endif
    );

    serial_subtractor #(.WIDTH(8), .DIGIT(4)) u84 (
        .clk(clk), .rst(rst), .in_valid(iv84), .in_ready(rdy84), .a(a84), .b(b84),
        .out_valid(ov84), .out_ready(or84), .diff(d84), .borrow(bo84), .busy(bz84)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        , .ovf(ovf84)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Two's-complement overflow from signed integer range, not from sign bits.
    function automatic logic ref_ovf8(input logic [7:0] x, input logic [7:0] y);
        int sx;
        int sy;
        int r;
        sx = x[7] ? int'(x) - 256 : int'(x);
        sy = y[7] ? int'(y) - 256 : int'(y);
        r  = sx - sy;
        return (r < -128) || (r > 127);
    endfunction

    task automatic run8(input logic [7:0] x, input logic [7:0] y);
        int n;
        logic [7:0] e;
        e = x - y;
        n = 0;
        while (!rdy8 && n < 50) begin step(); n++; end
        a8 = x; b8 = y; iv8 = 1'b1; or8 = 1'b1;
        step();
        iv8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        n = 0;
        while (!ov8 && n < 50) begin step(); n++; end
        check("lat8", n, 8);
        check("diff8", d8, e);
        check("borrow8", bo8, x < y);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        check("ovf8", ovf8, ref_ovf8(x, y));
`endif
        step();
        check("drop8", ov8, 1'b0);
    endtask

    task automatic run4(input logic [3:0] x, input logic [3:0] y);
        int n;
        n = 0;
        while (!rdy4 && n < 50) begin step(); n++; end
        a4 = x; b4 = y; iv4 = 1'b1; or4 = 1'b1;
        step();
        iv4 = 1'b0;
        n = 0;
        while (!ov4 && n < 50) begin step(); n++; end
        check("diff4", d4, (int'(x) - int'(y)) & 32'hF);
        check("borrow4", bo4, int'(x) < int'(y));
        step();
    endtask

    task automatic run84(input logic [7:0] x, input logic [7:0] y);
        int n;
        n = 0;
        while (!rdy84 && n < 50) begin step(); n++; end
        a84 = x; b84 = y; iv84 = 1'b1; or84 = 1'b1;
        step();
        iv84 = 1'b0;
        n = 0;
        while (!ov84 && n < 50) begin step(); n++; end
        check("lat84", n, 2);
        check("diff84", d84, (int'(x) - int'(y)) & 32'hFF);
        check("borrow84", bo84, int'(x) < int'(y));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        check("ovf84", ovf84, ref_ovf8(x, y));
`endif
        step();
        check("drop84", ov84, 1'b0);
    endtask

    initial begin
        int n;
        errors = 0;
        checks = 0;
        rst = 1'b1;
        iv8 = 0; a8 = 0; b8 = 0; or8 = 0;
        iv4 = 0; a4 = 0; b4 = 0; or4 = 0;
        iv84 = 0; a84 = 0; b84 = 0; or84 = 0;
        step();
        step();
        rst = 1'b0;
        check("rst_in_ready", rdy8, 1'b1);
        check("rst_out_valid", ov8, 1'b0);
        check("rst_diff", d8, 8'h00);
        check("rst_borrow", bo8, 1'b0);
        check("rst_busy", bz8, 1'b0);

        // Directed basics
        run8(8'h05, 8'h03);
        run8(8'h03, 8'h05);
        run8(8'h00, 8'h01);
        check("hold_idle_diff", d8, 8'hFF);

        // Exhaustive 4-bit
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                run4(4'(i), 4'(j));

        // Back-pressure with ignored in_valid pulses
        or8 = 1'b0; a8 = 8'hFF; b8 = 8'h0F; iv8 = 1'b1;
        step();
        iv8 = 1'b0;
        check("bp_busy", bz8, 1'b1);
        check("bp_rdy_busy", rdy8, 1'b0);
        n = 0;
        while (!ov8 && n < 50) begin step(); n++; end
        check("bp_lat", n, 8);
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", ov8, 1'b1);
            check("bp_diff", d8, 8'hF0);
            check("bp_borrow", bo8, 1'b0);
            check("bp_rdy", rdy8, 1'b0);
            iv8 = 1'(k & 1);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            step();
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        step();
        check("bp_drop", ov8, 1'b0);
        check("bp_rdy_after", rdy8, 1'b1);
        step();
        check("bp_no_queue", bz8, 1'b0);

        // Reset mid-operation
        a8 = 8'hAA; b8 = 8'h55; iv8 = 1'b1;
        step();
        iv8 = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_rdy", rdy8, 1'b1);
        check("mid_rst_valid", ov8, 1'b0);
        check("mid_rst_diff", d8, 8'h00);
        check("mid_rst_borrow", bo8, 1'b0);
        check("mid_rst_busy", bz8, 1'b0);
        step();
        check("mid_rst_stays", ov8, 1'b0);
        run8(8'h10, 8'h01);

        // DIGIT=4 directed
        run84(8'h80, 8'h01);
        run84(8'h7F, 8'h01);
        run84(8'h00, 8'h01);

        // Back-to-back with in_valid held
        a8 = 8'h3C; b8 = 8'h4D; iv8 = 1'b1; or8 = 1'b1;
        step();
        n = 0;
        while (!ov8 && n < 50) begin step(); n++; end
        check("b2b_lat1", n, 8);
        check("b2b_diff1", d8, 8'hEF);
        check("b2b_borrow1", bo8, 1'b1);
        a8 = 8'h99; b8 = 8'h11;
        step();
        check("b2b_rdy", rdy8, 1'b1);
        check("b2b_drop", ov8, 1'b0);
        step();
        check("b2b_accept", bz8, 1'b1);
        iv8 = 1'b0;
        n = 0;
        while (!ov8 && n < 50) begin step(); n++; end
        check("b2b_lat2", n, 8);
        check("b2b_diff2", d8, 8'h88);
        check("b2b_borrow2", bo8, 1'b0);
        step();

        // Randomized against the model
        repeat (30) run8(8'($urandom), 8'($urandom));
        repeat (30) run84(8'($urandom), 8'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
